// File: rtl/blackjack_pkg.sv
// Shared constants for the blackjack round controller: FSM encoding, result
// codes, card field positions and card scoring helpers.
package blackjack_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_PLACE  = 3'd3;
  localparam logic [2:0] S_P_TURN = 3'd4;
  localparam logic [2:0] S_D_TURN = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam int RANK_LSB = 0;
  localparam int RANK_MSB = 3;
  localparam int SUIT_LSB = 4;
  localparam int SUIT_MSB = 5;

  localparam logic [4:0] BLACKJACK = 5'd21;

  // Aces count 1 here; the soft +10 is applied by the hand's best score.
  function automatic logic [4:0] card_value(input logic [3:0] rank);
    card_value = (rank >= 4'd10) ? 5'd10 : {1'b0, rank};
  endfunction

endpackage

// File: rtl/blackjack_deal_ctrl_if.sv
// Card source handshake plus the accepted-card write port of the round controller.
interface blackjack_deal_ctrl_if;
  logic       card_req_o;
  logic       card_valid_i;
  logic [7:0] card_i;
  logic       card_we_o;
  logic       card_dest_o;
  logic [7:0] card_out_o;

  modport master (
    output card_req_o, card_we_o, card_dest_o, card_out_o,
    input  card_valid_i, card_i
  );

  modport slave (
    input  card_req_o, card_we_o, card_dest_o, card_out_o,
    output card_valid_i, card_i
  );
endinterface

// File: rtl/hand_accum.sv
// One blackjack hand: hard sum and ace flag, with a combinational best score.
module hand_accum
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] rank,
  output logic [4:0] hard_sum,
  output logic [4:0] best_score
);

  logic ace;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hard_sum <= '0;
      ace      <= 1'b0;
    end else if (clear) begin
      hard_sum <= '0;
      ace      <= 1'b0;
    end else if (add) begin
      hard_sum <= hard_sum + card_value(rank);
      ace      <= ace | (rank == 4'd1);
    end
  end

  assign best_score = (ace && hard_sum <= 5'd11) ? hard_sum + 5'd10 : hard_sum;

endmodule

// File: rtl/blackjack_deal_ctrl.sv
// Blackjack round controller: requests cards, routes them to player/dealer,
// runs player and dealer turns and reports the round result.
module blackjack_deal_ctrl
  import blackjack_pkg::*;
#(
  parameter int MAX_CARDS    = 11,  // assumed >= 4 so the initial deal always completes
  parameter int TIMEOUT      = 15,
  parameter int DEALER_STAND = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 hit_i,
  input  logic                 stand_i,
  blackjack_deal_ctrl_if.master card_bus,
  output logic [4:0]           player_score_o,
  output logic [4:0]           dealer_score_o,
  output logic [3:0]           cards_dealt_o,
  output logic [2:0]           state_o,
  output logic [1:0]           result_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [3:0] CARD_CAP  = 4'(MAX_CARDS);
  localparam logic [4:0] STAND_LVL = 5'(DEALER_STAND);

  logic [2:0]    state;
  logic          dest;
  logic          retry;
  logic [3:0]    cards_dealt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    result;
  logic [7:0]    card_q;

  logic [3:0] rank_in;
  logic       rank_ok;
  logic       at_cap;
  logic       new_round;
  logic       place;
  logic [4:0] player_hard, dealer_hard;
  logic [1:0] cmp_res;

  assign rank_in   = card_bus.card_i[RANK_MSB:RANK_LSB];
  assign rank_ok   = (rank_in != 4'd0) && (rank_in <= 4'd13);
  assign at_cap    = (cards_dealt == CARD_CAP);
  assign place     = (state == S_PLACE);
  assign new_round = start_i &&
                     (state == S_IDLE || state == S_RESULT || state == S_ERROR);

  hand_accum u_player (
    .clk(clk_i), .rst_n(rst_i), .clear(new_round), .add(place && !dest),
    .rank(card_q[RANK_MSB:RANK_LSB]), .hard_sum(player_hard), .best_score(player_score_o)
  );

  hand_accum u_dealer (
    .clk(clk_i), .rst_n(rst_i), .clear(new_round), .add(place && dest),
    .rank(card_q[RANK_MSB:RANK_LSB]), .hard_sum(dealer_hard), .best_score(dealer_score_o)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cmp_res = RES_PUSH;
    if (dealer_score_o > BLACKJACK)           cmp_res = RES_PLAYER;
    else if (player_score_o > dealer_score_o) cmp_res = RES_PLAYER;
    else if (player_score_o < dealer_score_o) cmp_res = RES_DEALER;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // only seen on a rising clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      dest        <= 1'b0;
      retry       <= 1'b0;
      cards_dealt <= '0;
      tmo_cnt     <= '0;
      result      <= RES_NONE;
      card_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_RESULT, S_ERROR: begin
          if (start_i) begin
            state       <= S_REQ;
            dest        <= 1'b0;
            retry       <= 1'b0;
            cards_dealt <= '0;
            result      <= RES_NONE;
          end
        end
        S_REQ: begin
          // A re-request after a discarded card keeps the running timeout.
          if (!retry) tmo_cnt <= TMO_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (card_bus.card_valid_i) begin
            if (rank_ok) begin
              card_q <= card_bus.card_i;
              retry  <= 1'b0;
              state  <= S_PLACE;
            end else begin
              retry <= 1'b1;
              state <= S_REQ;
            end
          end else if (tmo_cnt == '0) begin
            state <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        S_PLACE: begin
          cards_dealt <= cards_dealt + 4'd1;
          if (cards_dealt < 4'd3) begin
            dest  <= ~dest;
            state <= S_REQ;
          end else if (cards_dealt == 4'd3) begin
            state <= S_P_TURN;
          end else begin
            state <= dest ? S_D_TURN : S_P_TURN;
          end
        end
        S_P_TURN: begin
          if (player_hard > BLACKJACK) begin
            result <= RES_DEALER;
            state  <= S_RESULT;
          end else if ((cards_dealt == 4'd4 && player_score_o == BLACKJACK) || stand_i) begin
            state <= S_D_TURN;
          end else if (hit_i) begin
            if (at_cap) begin
              result <= cmp_res;
              state  <= S_RESULT;
            end else begin
              dest  <= 1'b0;
              state <= S_REQ;
            end
          end
        end
        S_D_TURN: begin
          if (dealer_score_o < STAND_LVL && !at_cap) begin
            dest  <= 1'b1;
            state <= S_REQ;
          end else begin
            result <= cmp_res;
            state  <= S_RESULT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign card_bus.card_req_o  = (state == S_REQ);
  assign card_bus.card_we_o   = place;
  assign card_bus.card_dest_o = place & dest;
  assign card_bus.card_out_o  = place ? card_q : 8'h00;

  assign cards_dealt_o = cards_dealt;
  assign state_o       = state;
  assign result_o      = result;
  assign done_o        = (state == S_RESULT);
  assign error_o       = (state == S_ERROR);

  logic unused_ok;
  assign unused_ok = ^dealer_hard;

endmodule

// File: tb/tb_blackjack_deal_ctrl.sv
// Directed self-checking bench for blackjack_deal_ctrl with a scripted card source.
module tb_blackjack_deal_ctrl;
  import blackjack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, hit, stand;
  logic [4:0] player_score, dealer_score;
  logic [3:0] cards_dealt;
  logic [2:0] state;
  logic [1:0] result;
  logic       done, error;

  blackjack_deal_ctrl_if bus ();

  blackjack_deal_ctrl #(.MAX_CARDS(11), .TIMEOUT(15), .DEALER_STAND(17)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .hit_i(hit), .stand_i(stand),
    .card_bus(bus), .player_score_o(player_score), .dealer_score_o(dealer_score),
    .cards_dealt_o(cards_dealt), .state_o(state), .result_o(result),
    .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  logic [8:0] we_log[$];

  always @(negedge clk) begin
    if (bus.card_req_o) req_cnt++;
    if (bus.card_we_o) we_log.push_back({bus.card_dest_o, bus.card_out_o});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !bus.card_req_o; i++) tick(1);
    check({tag, "_req"}, bus.card_req_o, 1);
  endtask

  // Answer the next request with one card; returns in the cycle after WAIT.
  task automatic serve(input string tag, input logic [7:0] card);
    wait_req(tag);
    tick(1);
    bus.card_valid_i = 1'b1;
    bus.card_i       = card;
    tick(1);
    bus.card_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !done; i++) tick(1);
    check({tag, "_done"}, done, 1);
  endtask

  int r0, w0;

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; stand = 1'b0;
    bus.card_valid_i = 1'b0; bus.card_i = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset while waiting for a card abandons the round silently.
    pulse_start();
    wait_req("rst");
    tick(1);
    check("rst_in_wait", state, S_WAIT);
    do_reset();
    check("rst_state", state, S_IDLE);
    check("rst_outputs", {bus.card_req_o, bus.card_we_o, bus.card_dest_o, bus.card_out_o,
                          player_score, dealer_score, cards_dealt, result, done, error}, 0);
    w0 = we_log.size();
    bus.card_valid_i = 1'b1; bus.card_i = 8'h15;
    tick(1);
    bus.card_valid_i = 1'b0;
    tick(2);
    check("rst_no_we", we_log.size(), w0);

    // Player blackjack, dealer 16 draws a 5 to 21: push.
    r0 = req_cnt; w0 = we_log.size();
    pulse_start();
    serve("bj1", 8'h0A);
    serve("bj2", 8'h19);
    serve("bj3", 8'h21);
    serve("bj4", 8'h37);
    tick(1);
    check("bj_pturn", state, S_P_TURN);
    check("bj_player21", player_score, 21);
    check("bj_dealer16", dealer_score, 16);
    check("bj_dealt4", cards_dealt, 4);
    stand = 1'b1;
    serve("bj5", 8'h05);
    stand = 1'b0;
    wait_done("bj");
    check("bj_result", result, RES_PUSH);
    check("bj_dealer21", dealer_score, 21);
    check("bj_reqs", req_cnt - r0, 5);
    check("bj_we_cnt", we_log.size() - w0, 5);
    check("bj_log0", we_log[w0],     {1'b0, 8'h0A});
    check("bj_log1", we_log[w0 + 1], {1'b1, 8'h19});
    check("bj_log2", we_log[w0 + 2], {1'b0, 8'h21});
    check("bj_log3", we_log[w0 + 3], {1'b1, 8'h37});
    check("bj_log4", we_log[w0 + 4], {1'b1, 8'h05});

    // Player 20 hits a queen and busts; dealer stays on its two cards.
    r0 = req_cnt;
    pulse_start();
    check("bust_cleared", {result, done}, 0);
    serve("bust1", 8'h1A);
    serve("bust2", 8'h05);
    serve("bust3", 8'h2A);
    serve("bust4", 8'h36);
    tick(1);
    check("bust_player20", player_score, 20);
    hit = 1'b1;
    serve("bust5", 8'h2C);
    hit = 1'b0;
    wait_done("bust");
    check("bust_result", result, RES_DEALER);
    check("bust_player30", player_score, 30);
    check("bust_dealer11", dealer_score, 11);
    check("bust_reqs", req_cnt - r0, 5);

    // Illegal ranks are discarded and re-requested.
    r0 = req_cnt; w0 = we_log.size();
    pulse_start();
    serve("bad0", 8'h00);
    serve("bad14", 8'h3E);
    serve("bad4", 8'h14);
    tick(1);
    check("bad_reqs", req_cnt - r0, 3);
    check("bad_we_cnt", we_log.size() - w0, 1);
    check("bad_we_card", we_log[w0], {1'b0, 8'h14});
    check("bad_player4", player_score, 4);
    check("bad_dealt1", cards_dealt, 1);

    // Timeout: 15 silent WAIT cycles, then ERROR; start recovers.
    do_reset();
    pulse_start();
    wait_req("tmo");
    tick(15);
    check("tmo_still_wait", {state, error}, {S_WAIT, 1'b0});
    tick(1);
    check("tmo_error", {state, error}, {S_ERROR, 1'b1});
    pulse_start();
    check("tmo_restart", {state, error, bus.card_req_o}, {S_REQ, 1'b0, 1'b1});
    tick(1);
    check("tmo_req_one_cycle", bus.card_req_o, 0);

    // Card cap: low cards and constant hitting stop at 11 cards.
    do_reset();
    r0 = req_cnt;
    pulse_start();
    serve("cap1", 8'h01);
    serve("cap2", 8'h1A);
    serve("cap3", 8'h11);
    serve("cap4", 8'h27);
    tick(1);
    check("cap_player12", player_score, 12);
    check("cap_dealer17", dealer_score, 17);
    hit = 1'b1;
    serve("cap5", 8'h21);
    serve("cap6", 8'h31);
    serve("cap7", 8'h02);
    serve("cap8", 8'h12);
    serve("cap9", 8'h22);
    serve("cap10", 8'h32);
    serve("cap11", 8'h03);
    wait_done("cap");
    hit = 1'b0;
    check("cap_dealt11", cards_dealt, 11);
    check("cap_player15", player_score, 15);
    check("cap_result", result, RES_DEALER);
    check("cap_reqs", req_cnt - r0, 11);
    tick(5);
    check("cap_no_12th", req_cnt - r0, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blackjack_deal_ctrl.md
# blackjack_deal_ctrl

Round controller for the card generator: it requests cards from the duplicate-free card source, routes each accepted card to the player or dealer hand, and runs one blackjack round. The sequence is initial deal, player hit/stand, dealer draw-to-threshold, then result. It sits between the card source (request/valid handshake) and the game UI/top level, and it is the only block allowed to drive the source's card request.

## Interface
- `MAX_CARDS`, default 11: cards per round; equals the card-history depth of the source.
- `TIMEOUT`, default 15: cycles allowed from request to `card_valid_i` before the round errors.
- `DEALER_STAND`, default 17: dealer draws while its score is below this value.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: synchronous, active-low reset.
- `start_i`, in, 1: pulse that begins a round.
- `hit_i`, in, 1: player requests a card; sampled only in P_TURN.
- `stand_i`, in, 1: player ends turn; sampled only in P_TURN; wins over `hit_i` when both are high.
- `card_req_o`, out, 1: one-cycle request pulse to the card source.
- `card_valid_i`, in, 1: `card_i` holds a fresh card.
- `card_i`, in, 8: bits [3:0] are the rank (1..13); bits [5:4] are the suit; bits [7:6] are ignored.
- `card_we_o`, out, 1: one-cycle strobe for an accepted card.
- `card_dest_o`, out, 1: destination of the accepted card; 0 = player, 1 = dealer. Valid with `card_we_o`.
- `card_out_o`, out, 8: the accepted card. Valid with `card_we_o`.
- `player_score_o`, out, 5: player best score.
- `dealer_score_o`, out, 5: dealer best score.
- `cards_dealt_o`, out, 4: cards accepted this round.
- `state_o`, out, 3: current FSM state.
- `result_o`, out, 2: 00 none, 01 player wins, 10 dealer wins, 11 push.
- `done_o`, out, 1: high in RESULT.
- `error_o`, out, 1: high in ERROR.

## Operation
- States:
  - IDLE
  - REQ
  - WAIT
  - PLACE
  - P_TURN
  - D_TURN
  - RESULT
  - ERROR
- IDLE, RESULT or ERROR + `start_i` → clear both hands, the count, `result_o` and `error_o`; set the deal index to 0; go to REQ. `start_i` is ignored in all other states.
- REQ: assert `card_req_o` for one cycle, load the timeout counter, go to WAIT.
- WAIT: `card_valid_i` is accepted only in this state; it is ignored elsewhere.
  - Valid with rank 0 or rank >13 → discard the card and return to REQ. The timeout counter is not reloaded on this path.
  - Valid with a legal rank → go to PLACE.
  - Counter expires → go to ERROR.
- PLACE: pulse `card_we_o` and present `card_dest_o`/`card_out_o`. Add the card value to the destination hand and increment `cards_dealt_o`.
- Card value: rank 1 = 1 with the ace flag set; ranks 2..10 = face value; ranks 11..13 = 10.
- Best score = hard sum + 10 when the ace flag is set and hard sum ≤ 11; otherwise best score = hard sum. The 5-bit hard sum cannot overflow, since the maximum is 21 + 10 = 31.
- Initial deal order is player, dealer, player, dealer; after each PLACE return to REQ until 4 cards are dealt, then go to P_TURN.
- P_TURN:
  - Player score 21 after the initial deal → go straight to D_TURN.
  - `stand_i` → D_TURN.
  - `hit_i` → REQ with destination player.
  - After a player card: hard sum >21 → RESULT with 10; otherwise back to P_TURN.
- D_TURN: dealer score < `DEALER_STAND` → REQ with destination dealer; otherwise go to RESULT with a compare.
- Compare:
  - Dealer >21 → 01.
  - Player > dealer → 01.
  - Player < dealer → 10.
  - Equal → 11.
- Card cap: if a card is needed while `cards_dealt_o` == `MAX_CARDS`, go to RESULT with a compare instead of REQ.
- RESULT and ERROR hold until `start_i` or reset.

## Timing
- Reset: on the next edge, state IDLE and all outputs 0. Reset mid-round abandons the round with no output strobes.
- `card_req_o` is high exactly 1 cycle per request. Never more than one request is outstanding.
- Accepted card: `card_we_o` is high the cycle after the `card_valid_i` sample in WAIT. Scores update the cycle after `card_we_o`.
- Timeout: with no `card_valid_i` in the `TIMEOUT` cycles after the REQ cycle, the FSM enters ERROR on the following edge.
- `hit_i`/`stand_i` are level-sampled once per P_TURN cycle and are ignored while a card is in flight.

## Structure
- Package `blackjack_pkg` holds:
  - the state encoding;
  - the result codes (`RES_NONE`, `RES_PLAYER`, `RES_DEALER`, `RES_PUSH`);
  - the rank and suit field positions;
  - a `card_value` function;
  - the blackjack constant 21.
- Sub-module `hand_accum`, instantiated twice (player and dealer):
  - inputs: clear, add strobe, rank;
  - state: hard sum, ace flag;
  - output: combinational best score.

## Test plan
- Reset mid-WAIT → next cycle state IDLE, all outputs 0; `card_valid_i` afterwards → no `card_we_o`.
- `start_i`; source supplies ranks 10, 9, 1, 7; then `stand_i`:
  - destinations 0, 1, 0, 1;
  - player score 21;
  - dealer hard sum 16 → dealer hits;
  - a rank-5 card gives dealer 21 → `result_o` = 11.
- Player gets 10, 10, then hits a rank-12 card → player hard sum 30, `result_o` = 10; the dealer draws nothing.
- Source returns rank 0, then rank 14, then rank 4 → exactly 3 `card_req_o` pulses and one `card_we_o` carrying rank 4.
- No `card_valid_i` for 15 cycles after a request → `error_o` = 1; a later `start_i` clears it and issues a new request.
- Low ranks with the player hitting repeatedly → deal stops at 11 cards, no 12th request, and RESULT is entered with a compare.
